bram_port_arbiter: RTL

- Shares one single-ported BRAM master port between N_REQ narrow requesters, using round-robin arbitration.
- Sits between several controllers (e.g. a DMA engine and a CPU-side slave) and one BRAM port, optionally behind a data width converter.
- Tracks the BRAM read latency internally and steers a read-valid strobe back to the requester that issued each read.

---
 rtl/bram_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among N_REQ requesters, with read-valid steering.
// Optional grant locking is compiled in with `define BRAM_ARB_LOCK_EN.
module bram_port_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_BITW      = 32,
  parameter int DATA_BITW      = 32,
  parameter int RD_LAT         = 1,
  parameter int MAX_LOCK_BEATS = 8
) (
  input  logic                           Clk_C,
  input  logic                           Rst_R,
  input  logic [N_REQ-1:0]               Req_S,
  output logic [N_REQ-1:0]               Gnt_S,
  input  logic [N_REQ*ADDR_BITW-1:0]     Addr_S,
  input  logic [N_REQ*DATA_BITW/8-1:0]   WrEn_S,
  input  logic [N_REQ*DATA_BITW-1:0]     Wr_D,
  output logic [DATA_BITW-1:0]           Rd_D,
  output logic [N_REQ-1:0]               RdValid_S,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]               Lock_S,
`endif
  output logic                           BramEn_S,
  output logic [ADDR_BITW-1:0]           BramAddr_S,
  output logic [DATA_BITW/8-1:0]         BramWrEn_S,
  output logic [DATA_BITW-1:0]           BramWr_D,
  input  logic [DATA_BITW-1:0]           BramRd_D
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BE_W = DATA_BITW / 8;

  logic [ADDR_BITW-1:0] addr_a [N_REQ];
  logic [BE_W-1:0]      wren_a [N_REQ];
  logic [DATA_BITW-1:0] wdat_a [N_REQ];

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            lock_hit;
  logic            rd_push;

  logic [RD_LAT-1:0] rd_vld_q;
  logic [ID_W-1:0]   rd_id_q [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_a[gi]    = Addr_S[gi*ADDR_BITW +: ADDR_BITW];
      assign wren_a[gi]    = WrEn_S[gi*BE_W +: BE_W];
      assign wdat_a[gi]    = Wr_D[gi*DATA_BITW +: DATA_BITW];
      assign Gnt_S[gi]     = gnt_found && (gnt_id == ID_W'(gi));
      assign RdValid_S[gi] = rd_vld_q[RD_LAT-1] && (rd_id_q[RD_LAT-1] == ID_W'(gi));
    end
  endgenerate

`ifdef BRAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK_BEATS) + 1;

  logic             holder_vld_q;
  logic [ID_W-1:0]  holder_q;
  logic [CNT_W-1:0] lock_cnt_q;

  // lock_cnt_q counts locked re-grants, so total consecutive grants is lock_cnt_q + 1
  assign lock_hit = holder_vld_q && Req_S[holder_q] && Lock_S[holder_q] &&
                    (lock_cnt_q < CNT_W'(MAX_LOCK_BEATS - 1));

  always_ff @(posedge Clk_C or posedge Rst_R) begin
    if (Rst_R) begin
      holder_vld_q <= 1'b0;
      holder_q     <= '0;
      lock_cnt_q   <= '0;
    end else begin
      holder_vld_q <= gnt_found;
      holder_q     <= gnt_id;
      lock_cnt_q   <= lock_hit ? lock_cnt_q + CNT_W'(1) : '0;
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  // Scan Ptr, Ptr+1, ... and take the first requester; an active lock overrides the scan
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_found && Req_S[(int'(ptr_q) + k) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
    if (lock_hit) begin
      gnt_found = 1'b1;
      gnt_id    = holder_q_sel();
    end
  end

  function automatic logic [ID_W-1:0] holder_q_sel();
`ifdef BRAM_ARB_LOCK_EN
    return holder_q;
`else
    return ptr_q;
`endif
  endfunction

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found && !lock_hit) begin
      ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  assign BramEn_S   = gnt_found;
  assign BramAddr_S = gnt_found ? addr_a[gnt_id] : '0;
  assign BramWrEn_S = gnt_found ? wren_a[gnt_id] : '0;
  assign BramWr_D   = gnt_found ? wdat_a[gnt_id] : '0;
  assign Rd_D       = BramRd_D;
  assign rd_push    = gnt_found && (BramWrEn_S == '0);

  always_ff @(posedge Clk_C or posedge Rst_R) begin
    if (Rst_R) begin
      ptr_q    <= '0;
      rd_vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) rd_id_q[s] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rd_vld_q[0] <= rd_push;
      rd_id_q[0]  <= gnt_id;
      for (int s = 1; s < RD_LAT; s++) begin
        rd_vld_q[s] <= rd_vld_q[s-1];
        rd_id_q[s]  <= rd_id_q[s-1];
      end
    end
  end

endmodule
